// File: rtl/dpi_tick_scheduler_pkg.sv
// Shared types for the DPI tick scheduler: FSM states, call descriptor,
// and the group-index width helper.
package dpi_tick_sched_pkg;

    // Widest group index ever needed (32 groups).
    localparam int GRP_MAX_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;

    // One call descriptor: either the main tick or a group tick.
    typedef struct packed {
        logic                 main;
        logic [GRP_MAX_W-1:0] grp;
    } dpi_desc_t;

    // Group index width, never narrower than one bit.
    function automatic int grp_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dpi_tick_scheduler_if.sv
// Call-descriptor handshake between the scheduler and the DPI call shim.
interface dpi_tick_scheduler_if #(
    parameter int GRP_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic             out_main;
    logic [GRP_W-1:0] out_grp;

    modport master (output out_valid, output out_main, output out_grp, input out_ready);
    modport slave  (input out_valid, input out_main, input out_grp, output out_ready);
endinterface

// File: rtl/dpi_rr_arbiter.sv
// Combinational round-robin pick: first requesting group after ptr.
module dpi_rr_arbiter #(
    parameter int NUM_GROUPS = 5,
    parameter int GRP_W      = 3
) (
    input  logic [NUM_GROUPS-1:0] req,
    input  logic [GRP_W-1:0]      ptr,
    output logic [NUM_GROUPS-1:0] gnt,
    output logic [GRP_W-1:0]      idx,
    output logic                  any
);
    // Scan ptr+1 .. ptr+NUM_GROUPS (mod NUM_GROUPS); the pointer itself is last.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 1; i <= NUM_GROUPS; i++) begin
            j = (int'(ptr) + i) % NUM_GROUPS;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = GRP_W'(j);
            end
        end
    end
endmodule

// File: rtl/dpi_tick_scheduler.sv
// DPI tick scheduler: turns per-group trigger fires and the frame pulse
// into a stream of call descriptors, one per handshake.
// Optional grant statistics: define DPI_TICK_SCHED_STATS_EN.
module dpi_tick_scheduler
    import dpi_tick_sched_pkg::*;
#(
    parameter int NUM_GROUPS     = 5,
    parameter int PEND_W         = 3,
    parameter int MAIN_STALL_MAX = 8,
    parameter int GRP_W          = grp_w(NUM_GROUPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_GROUPS-1:0] trig,
    input  logic                  frame,
    input  logic                  ovf_clr,
    output logic [NUM_GROUPS-1:0] ovf,
    output logic                  busy,
    dpi_tick_scheduler_if.master  bus
`ifdef DPI_TICK_SCHED_STATS_EN
   ,input  logic [GRP_W-1:0]      stat_sel,
    output logic [31:0]           stat_count
`endif
);
    localparam int                 STALL_W   = $clog2(MAIN_STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAIN_STALL_MAX);
    localparam logic [PEND_W-1:0]  PEND_MAX  = '1;

    sched_state_e                       state;
    logic [NUM_GROUPS-1:0][PEND_W-1:0]  pend;
    logic [NUM_GROUPS-1:0]              last, fire, req, gnt, dec, ovf_set;
    logic                               main_pend;
    logic [STALL_W-1:0]                 stall;
    logic [GRP_W-1:0]                   ptr, arb_idx;
    logic                               arb_any;
    dpi_desc_t                          slot;
    logic                               out_valid;
    logic                               in_run, active, slot_free, main_urgent;
    logic                               load_main, load_grp;
    logic                               unused_grp_bits;

    dpi_rr_arbiter #(.NUM_GROUPS(NUM_GROUPS), .GRP_W(GRP_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign bus.out_valid   = out_valid;
    assign bus.out_main    = slot.main;
    assign bus.out_grp     = slot.grp[GRP_W-1:0];
    assign unused_grp_bits = ^slot.grp;

    // Slot loading decision: an aged main tick preempts, otherwise groups, then main.
    always_comb begin
        in_run      = (state == RUN);
        active      = (state != IDLE);
        slot_free   = !out_valid || bus.out_ready;
        main_urgent = main_pend && (stall >= STALL_LIM);
        load_main   = active && slot_free && (main_urgent || (!arb_any && main_pend));
        load_grp    = active && slot_free && !main_urgent && arb_any;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            req[g] = (pend[g] != '0);
        end
        // trig | (trig ^ last) reduces to trig | last: level high or just fell.
        fire    = in_run ? (trig | last) : '0;
        dec     = load_grp ? gnt : '0;
        ovf_set = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            ovf_set[g] = fire[g] && !dec[g] && (pend[g] == PEND_MAX);
        end
    end

    // Per-group saturating pending counters, trigger history and overflow flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            last <= '0;
            ovf  <= '0;
        end else begin
            last <= trig;
            ovf  <= (ovf & ~{NUM_GROUPS{ovf_clr}}) | ovf_set;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (fire[g] && !dec[g] && !ovf_set[g]) pend[g] <= pend[g] + 1'b1;
                else if (!fire[g] && dec[g])           pend[g] <= pend[g] - 1'b1;
            end
        end
    end

    // Main tick request and its starvation age.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_pend <= 1'b0;
            stall     <= '0;
        end else begin
            if (in_run && frame) main_pend <= 1'b1;
            else if (load_main)  main_pend <= 1'b0;
            if (load_main)                           stall <= '0;
            else if (main_pend && stall != STALL_LIM) stall <= stall + 1'b1;
        end
    end

    // Registered output slot and round-robin pointer. The pointer starts at
    // the last group so that group 0 wins the first contest after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            slot      <= '0;
            ptr       <= GRP_W'(NUM_GROUPS - 1);
        end else if (active && slot_free) begin
            out_valid <= load_main || load_grp;
            if (load_main) begin
                slot <= '{main: 1'b1, grp: '0};
            end else if (load_grp) begin
                slot <= '{main: 1'b0, grp: GRP_MAX_W'(arb_idx)};
                ptr  <= arb_idx;
            end
        end
    end

    // Run-state FSM with registered busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (!(|req) && !main_pend && !out_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DPI_TICK_SCHED_STATS_EN
    logic [NUM_GROUPS-1:0][31:0] grant_cnt;

    // Per-group accepted-grant counters and registered readback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt  <= '0;
            stat_count <= '0;
        end else begin
            if (out_valid && bus.out_ready && !slot.main)
                grant_cnt[slot.grp[GRP_W-1:0]] <= grant_cnt[slot.grp[GRP_W-1:0]] + 32'd1;
            stat_count <= (int'(stat_sel) < NUM_GROUPS) ? grant_cnt[stat_sel] : 32'd0;
        end
    end
`endif

endmodule

// File: tb/tb_dpi_tick_scheduler.sv
// Bench for dpi_tick_scheduler: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_dpi_tick_scheduler;
    localparam int N    = 5;
    localparam int PMAX = 7;
    localparam int SMAX = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   trig = '0;
    logic           frame = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [N-1:0]   ovf;
    logic           busy;
`ifdef DPI_TICK_SCHED_STATS_EN
    logic [2:0]     stat_sel = '0;
    logic [31:0]    stat_count;
`endif

    dpi_tick_scheduler_if #(.GRP_W(3)) bus ();

    dpi_tick_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .trig    (trig),
        .frame   (frame),
        .ovf_clr (ovf_clr),
        .ovf     (ovf),
        .busy    (busy),
        .bus     (bus)
`ifdef DPI_TICK_SCHED_STATS_EN
       ,.stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, clock one edge, return at the following negedge.
    task automatic step(input logic en, input logic [N-1:0] t, input logic fr,
                        input logic rdy, input logic clr);
        enable = en; trig = t; frame = fr; bus.out_ready = rdy; ovf_clr = clr;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        enable = 1'b0; trig = '0; frame = 1'b0; bus.out_ready = 1'b0; ovf_clr = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ovf_busy", {ovf, busy}, 0);
        reset = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_stall, m_ptr, m_grp;
    int m_pend[N];
    bit m_last[N], m_ovf[N];
    bit m_mp, m_v, m_main;

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_ptr = N - 1; m_grp = 0;
        m_mp = 0; m_v = 0; m_main = 0;
        for (int g = 0; g < N; g++) begin m_pend[g] = 0; m_last[g] = 0; m_ovf[g] = 0; end
    endtask

    task automatic model_edge(input bit en, input logic [N-1:0] t, input bit fr,
                              input bit rdy, input bit clr);
        int  pick, np, g;
        bit  run, act, quiet, take;
        run   = (m_state == 1);
        act   = (m_state != 0);
        take  = act && (!m_v || rdy);
        quiet = !m_mp && !m_v;
        for (int k = 0; k < N; k++) if (m_pend[k] != 0) quiet = 0;
        pick = -2;
        if (take) begin
            if (m_mp && m_stall >= SMAX) pick = -1;
            else begin
                for (int k = 1; k <= N; k++) begin
                    g = (m_ptr + k) % N;
                    if (pick == -2 && m_pend[g] > 0) pick = g;
                end
                if (pick == -2 && m_mp) pick = -1;
            end
        end
        for (int k = 0; k < N; k++) begin
            np = m_pend[k] + ((run && (t[k] || m_last[k])) ? 1 : 0) - ((pick == k) ? 1 : 0);
            if (clr) m_ovf[k] = 0;
            if (np > PMAX) begin np = PMAX; m_ovf[k] = 1; end
            m_pend[k] = np;
            m_last[k] = t[k];
        end
        if (pick == -1) m_stall = 0; else if (m_mp) m_stall++;
        if (run && fr) m_mp = 1; else if (pick == -1) m_mp = 0;
        if (take) begin
            m_v = (pick != -2);
            if (pick == -1) m_main = 1;
            else if (pick >= 0) begin m_main = 0; m_grp = pick; m_ptr = pick; end
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 2;
            default: if (en) m_state = 1; else if (quiet) m_state = 0;
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit en; logic [N-1:0] t; bit fr; bit rdy; bit clr;
        bit ev; bit em; int eg; logic [N-1:0] eovf; bit eb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit en, logic [N-1:0] t, bit rdy,
                                bit ev, int eg, bit eb);
        vec_t v;
        v.rst = rst; v.en = en; v.t = t; v.fr = 0; v.rdy = rdy; v.clr = 0;
        v.ev = ev; v.em = 0; v.eg = eg; v.eovf = '0; v.eb = eb;
        return v;
    endfunction

    initial begin
        int k, hs, main_at;
        logic [N-1:0] tv;
        bit en_r;

        // Single pulse on group 2: two fires, two descriptors, then drain to idle.
        vt.push_back(mk(1, 1, 5'b00000, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 5'b00100, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 5'b00000, 1, 1, 2, 1));
        vt.push_back(mk(0, 1, 5'b00000, 1, 1, 2, 1));
        vt.push_back(mk(0, 1, 5'b00000, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 0));
        // Held 10101: round-robin 0,2,4,0,2,4.
        vt.push_back(mk(1, 1, 5'b00000, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 0, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 2, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 4, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 0, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 2, 1));
        vt.push_back(mk(0, 1, 5'b10101, 1, 1, 4, 1));

        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            step(vt[i].en, vt[i].t, vt[i].fr, vt[i].rdy, vt[i].clr);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_main", i), 32'(bus.out_main), 32'(vt[i].em));
                chk($sformatf("vec%0d_grp", i), 32'(bus.out_grp), 32'(vt[i].eg));
            end
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].eovf));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].eb));
        end

        // Saturation: group 1 held high with the port stalled.
        do_reset();
        step(1, 5'b00000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 5'b00010, 0, 0, 0);
            if (i >= 1) begin
                chk("sat_valid", 32'(bus.out_valid), 1);
                chk("sat_grp_stable", 32'(bus.out_grp), 1);
            end
        end
        chk("sat_ovf", 32'(ovf), 32'b00010);
        step(1, 5'b00010, 0, 0, 1);
        chk("ovf_set_wins", 32'(ovf), 32'b00010);
        step(1, 5'b00000, 0, 0, 0);
        step(1, 5'b00000, 0, 0, 1);
        chk("ovf_clr", 32'(ovf), 0);

        // Frame while group 0 is held: main ages out after SMAX grants.
        do_reset();
        step(1, 5'b00000, 0, 1, 0);
        step(1, 5'b00001, 1, 1, 0);
        main_at = 0;
        for (int i = 1; i <= 12 && main_at == 0; i++) begin
            step(1, 5'b00001, 0, 1, 0);
            if (bus.out_valid && bus.out_main) main_at = i;
        end
        chk("main_latency", 32'(main_at), SMAX + 1);
        step(1, 5'b00001, 0, 1, 0);
        chk("main_resume", {bus.out_valid, bus.out_main, 29'(bus.out_grp)}, {1'b1, 1'b0, 29'd0});

        // Drain: three descriptors for group 3, trigger changes ignored.
        do_reset();
        step(1, 5'b00000, 0, 0, 0);
        step(1, 5'b01000, 0, 0, 0);
        step(1, 5'b01000, 0, 0, 0);
        step(1, 5'b00000, 0, 0, 0);
        hs = 0;
        k  = 0;
        while (busy && k < 30) begin
            if (bus.out_valid) begin
                hs++;
                chk("drain_grp", {bus.out_main, 29'(bus.out_grp)}, 32'd3);
            end
            tv = (k == 0) ? 5'b00000 : 5'($urandom);
            step(0, tv, (k != 0), 1, 0);
            k++;
        end
        chk("drain_handshakes", 32'(hs), 3);
        chk("drain_idle", 32'(busy), 0);
        step(0, 5'b11111, 1, 1, 0);
        chk("drain_no_more", 32'(bus.out_valid), 0);

        // Async reset mid-handshake, then no stale descriptor.
        do_reset();
        step(1, 5'b00000, 0, 0, 0);
        step(1, 5'b00001, 0, 0, 0);
        step(1, 5'b00000, 0, 0, 0);
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        #2 reset = 1'b0;
        #1 chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 5'b00000, 0, 1, 0);
            chk("no_stale", 32'(bus.out_valid), 0);
        end

        // Random traffic against the model.
        do_reset();
        model_reset();
        en_r = 1;
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] rt;
            bit rf, rr, rc;
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            rt = 5'($urandom) & 5'($urandom);
            rf = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 9) < 6);
            rc = ($urandom_range(0, 19) == 0);
            step(en_r, rt, rf, rr, rc);
            model_edge(en_r, rt, rf, rr, rc);
            begin
                logic [N-1:0] eo;
                for (int g = 0; g < N; g++) eo[g] = m_ovf[g];
                chk($sformatf("rnd%0d_valid_busy_ovf", i), {bus.out_valid, busy, ovf},
                    {m_v, m_state != 0, eo});
                if (m_v) begin
                    chk($sformatf("rnd%0d_main", i), 32'(bus.out_main), 32'(m_main));
                    if (!m_main) chk($sformatf("rnd%0d_grp", i), 32'(bus.out_grp), 32'(m_grp));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end
endmodule

// File: doc/dpi_tick_scheduler.md
Name: dpi_tick_scheduler

Overview:
Sequences DPI exporter tick calls for a design with multiple sensitive groups plus one unconditional main tick.
- Each cycle, detects per-group fire conditions (trigger high, or trigger falling edge).
- Queues firings as saturating per-group pending counts.
- Issues exactly one call descriptor per handshake to a single downstream DPI call port.
- Sits between the generated trigger taps and the DPI call shim.

Parameters:
NUM_GROUPS, 5, number of sensitive groups (1..32)
PEND_W, 3, pending counter width per group; saturates at 2**PEND_W-1
MAIN_STALL_MAX, 8, cycles the main tick may wait before it preempts group grants
GRP_W, $clog2(NUM_GROUPS) min 1, derived; group index width

Ports:
clock  input  1  sole clock
reset  input  1  asynchronous, active-low reset
enable  input  1  scheduler run enable
trig  input  NUM_GROUPS  per-group trigger (OR of that group's trigger signals)
frame  input  1  one-cycle pulse requesting the main tick
out_valid  output  1  call descriptor valid
out_ready  input  1  downstream accepts descriptor
out_main  output  1  descriptor is the main tick (out_grp ignored)
out_grp  output  GRP_W  group index to call
ovf  output  NUM_GROUPS  sticky per-group pending-overflow flags
ovf_clr  input  1  clears all ovf bits
busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync release) clears:
  - out_valid, out_main, out_grp, ovf, busy = 0
  - all pending counts, last-trigger regs, main_pend and stall counter = 0
  - state = IDLE
- Fire condition per group g, sampled every clock edge in RUN: fire[g] = trig[g] | (trig[g] ^ last[g]). last[g] <= trig[g] every cycle regardless of state.
- Pending update per group, same edge: pend += fire, minus 1 if g is loaded into the output slot this edge.
  - Increment and decrement on the same edge: net unchanged.
  - Increment at max: count stays at max and ovf[g] is set.
  - ovf_clr clears ovf; a simultaneous set wins.
- frame sets main_pend (no count; a second frame while pending is absorbed).
  - Stall counter increments each cycle main_pend=1 and main is not loaded.
  - Stall counter clears when main is loaded.
- Output slot is registered.
  - Slot loads when (!out_valid | out_ready) and a candidate exists.
  - While out_valid & !out_ready, out_main and out_grp hold stable.
  - Selection priority: main if stall counter >= MAIN_STALL_MAX; else round-robin over groups with pend>0, starting after the last granted group; else main if main_pend; else out_valid drops to 0.
- Latency: trig asserted before edge E0 gives pend after E0 and out_valid after E1 (2 edges), with an idle slot.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN: no new fire/frame sampling; serve remaining pending and main. DRAIN -> IDLE when all pend=0, main_pend=0 and no descriptor outstanding. DRAIN -> RUN if enable reasserts.
  - IDLE: no sampling, no loads.
- Reset mid-handshake: descriptor is dropped and all queued work is discarded.

Optional Feature:
DPI_TICK_SCHED_STATS_EN
- Defined: adds input stat_sel[GRP_W] and output stat_count[32].
  - One 32-bit wrapping grant counter per group, incremented on each accepted handshake for that group.
  - stat_count is the registered count of the selected group, 1-cycle read latency.
  - Counters reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dpi_tick_sched_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - grp_w(n) function
  - descriptor struct {main, grp}
- One sub-module, dpi_rr_arbiter:
  - parameterized NUM_GROUPS round-robin pick
  - inputs: request mask, last-grant pointer
  - outputs: one-hot grant, index, any
  - purely combinational; pointer register lives in the parent

Test Plan:
- Reset then enable=1, trig[2] pulse high for 1 cycle -> fire on rising and falling edge; two descriptors, grp=2 each; out_valid 2 edges after the rise.
- trig=5'b10101 held, out_ready=1 -> grant order 0,2,4,0,2,4…; no ovf.
- out_ready=0 for 10 cycles with trig[1] held high -> pend[1] saturates at 7, ovf[1]=1; out_grp stable throughout. Then ovf_clr -> ovf=0.
- frame pulse while trig[0] held, out_ready=1 -> main loaded within MAIN_STALL_MAX+1 cycles (out_main=1), then group grants resume.
- Pending 3 on grp 3, enable=0 -> state DRAIN; 3 descriptors issued; busy falls after the last handshake; trig changes during DRAIN are ignored.
- Reset asserted with out_valid=1 -> out_valid=0 immediately, without a clock edge; after release, no stale descriptor appears.
